// File: rtl/acc_window_if.sv
// Sample-in / result-out stream bundle for acc_window_ctrl.
// The slave modport is the controller's view; master is the source/sink side.
interface acc_window_if #(
   parameter int unsigned DATA_W = 18,
   parameter int unsigned ACC_W  = 28
);
   logic signed [DATA_W-1:0] s_data;
   logic                     s_valid;
   logic                     s_ready;
   logic signed [ACC_W-1:0]  m_sum;
   logic                     m_valid;
   logic                     m_ready;
   logic                     m_ovf;

   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_sum, m_valid, m_ovf
   );

   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_sum, m_valid, m_ovf
   );
endinterface

// File: rtl/acc_window_ctrl.sv
// Window sequencer for an external signed accumulator: clear, gate samples, capture, emit.
// Optional overflow detection is enabled by defining ACC_OVF_DET_EN.
module acc_window_ctrl #(
   parameter int unsigned DATA_W  = 18,
   parameter int unsigned ACC_W   = 28,
   parameter int unsigned WIN_LEN = 1920
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   acc_window_if.slave              win_if,
   output logic signed [DATA_W-1:0] acc_a_o,
   output logic                     acc_ce_o,
   output logic                     acc_rst_o,
   input  logic signed [ACC_W-1:0]  acc_y_i,
   output logic                     busy_o
);

   localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIN_LEN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StAccum,
      StSettle,
      StOutput
   } state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic signed [ACC_W-1:0] m_sum_q;
   logic                    m_valid_q;
   logic                    hs;

   assign hs        = (state_q == StAccum) && win_if.s_valid;
   assign acc_a_o   = win_if.s_data;
   assign acc_ce_o  = hs;
   // Accumulator is also cleared while the controller itself is in reset.
   assign acc_rst_o = rst_i || (state_q == StClear);
   assign busy_o    = (state_q != StIdle);

   assign win_if.s_ready = (state_q == StAccum);
   assign win_if.m_sum   = m_sum_q;
   assign win_if.m_valid = m_valid_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         m_sum_q   <= '0;
         m_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) state_q <= StClear;
            end
            StClear: begin
               cnt_q   <= '0;
               state_q <= StAccum;
            end
            StAccum: begin
               if (hs) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CntLast) state_q <= StSettle;
               end
            end
            StSettle: begin
               // acc_y_i already holds the last sample here.
               m_sum_q   <= acc_y_i;
               m_valid_q <= 1'b1;
               state_q   <= StOutput;
            end
            StOutput: begin
               if (win_if.m_ready) begin
                  m_valid_q <= 1'b0;
                  state_q   <= start_i ? StClear : StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef ACC_OVF_DET_EN
   logic signed [ACC_W:0] ovf_sum;
   logic                  ovf_hit;
   logic                  ovf_q;
   logic                  m_ovf_q;

   // One guard bit: top two bits differing means the wrapped sum is wrong.
   assign ovf_sum = {acc_y_i[ACC_W-1], acc_y_i} + (ACC_W + 1)'(win_if.s_data);
   assign ovf_hit = ovf_sum[ACC_W] ^ ovf_sum[ACC_W-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q   <= 1'b0;
         m_ovf_q <= 1'b0;
      end else begin
         if (state_q == StClear) begin
            ovf_q <= 1'b0;
         end else if (hs && ovf_hit) begin
            ovf_q <= 1'b1;
         end
         if (state_q == StSettle) m_ovf_q <= ovf_q;
      end
   end

   assign win_if.m_ovf = m_ovf_q;
`else
   assign win_if.m_ovf = 1'b0;
`endif

endmodule
